// File: rtl/parallel_converter_1_to_n_flow.sv
`default_nettype none
// ============================================================================
// Module   : parallel_converter_1_to_n_flow
// Purpose  : Gathers NB_DATA-bit blocks into bundles of up to N_LANES blocks
//            with valid/ready flow control, flush and runtime lane count.
//            Optional SOF realignment: define PAR_CONV_SOF_ALIGN_EN.
// Revision : 1.0
// ============================================================================
module parallel_converter_1_to_n_flow #(
    parameter int NB_DATA     = 67,
    parameter int N_LANES     = 20,
    parameter int NB_DATA_BUS = NB_DATA * N_LANES,
    parameter int NB_COUNT    = $clog2(N_LANES + 1)
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_valid,
    input  logic [NB_DATA-1:0]     i_data,
    output logic                   o_ready,
    input  logic                   i_flush,
    input  logic [NB_COUNT-1:0]    i_n_lanes,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [NB_DATA_BUS-1:0] o_data,
    output logic [NB_COUNT-1:0]    o_n_lanes,
    output logic                   o_overflow
`ifdef PAR_CONV_SOF_ALIGN_EN
    ,
    input  logic                   i_sof
`endif
);

    localparam logic [NB_COUNT-1:0] C_MAX = NB_COUNT'(N_LANES);
    localparam logic [NB_COUNT-1:0] C_ONE = NB_COUNT'(1);

    logic [NB_DATA_BUS-1:0] r_asm;
    logic [NB_COUNT-1:0]    r_idx;
    logic [NB_COUNT-1:0]    r_tgt;
    logic                   r_pend;
    logic                   r_oval;
    logic [NB_DATA_BUS-1:0] r_out;
    logic [NB_COUNT-1:0]    r_out_n;
    logic                   r_ovf;

    logic                   w_acc;
    logic                   w_xfer;
    logic                   w_free;
    logic                   w_sof_drop;
    logic [NB_COUNT-1:0]    w_base_idx;
    logic [NB_COUNT-1:0]    w_nl_clamp;
    logic [NB_COUNT-1:0]    w_tgt_cur;
    logic [NB_COUNT-1:0]    w_cnt_new;
    logic [NB_DATA_BUS-1:0] w_asm_new;
    logic                   w_done;

    always_comb begin
        w_acc  = i_enable & i_valid & ~r_pend;
        w_xfer = i_enable & r_oval & i_ready;
        w_free = ~r_oval | w_xfer;
`ifdef PAR_CONV_SOF_ALIGN_EN
        w_sof_drop = w_acc & i_sof & (r_idx != '0);
`else
        w_sof_drop = 1'b0;
`endif
        // An SOF block restarts assembly as if the index were already zero
        w_base_idx = w_sof_drop ? '0 : r_idx;
        w_asm_new  = w_sof_drop ? '0 : r_asm;
        w_nl_clamp = ((i_n_lanes == '0) || (i_n_lanes > C_MAX)) ? C_MAX : i_n_lanes;
        w_tgt_cur  = (w_base_idx == '0) ? w_nl_clamp : r_tgt;
        if (w_acc) begin
            for (int k = 0; k < N_LANES; k++) begin
                if (w_base_idx == NB_COUNT'(k)) begin
                    w_asm_new[NB_DATA_BUS-1-k*NB_DATA -: NB_DATA] = i_data;
                end
            end
        end
        w_cnt_new = w_base_idx + (w_acc ? C_ONE : '0);
        w_done    = ~r_pend &
                    ((w_acc & (w_base_idx == (w_tgt_cur - C_ONE))) |
                     (i_enable & i_flush & (w_cnt_new != '0)));
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_asm   <= '0;
            r_idx   <= '0;
            r_tgt   <= C_MAX;
            r_pend  <= 1'b0;
            r_oval  <= 1'b0;
            r_out   <= '0;
            r_out_n <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_done) begin
                if (w_free) begin
                    r_out   <= w_asm_new;
                    r_out_n <= w_cnt_new;
                    r_oval  <= 1'b1;
                    r_asm   <= '0;
                    r_idx   <= '0;
                end else begin
                    // While pending, r_idx holds the bundle's block count
                    r_pend <= 1'b1;
                    r_asm  <= w_asm_new;
                    r_idx  <= w_cnt_new;
                end
            end else if (r_pend & w_xfer) begin
                r_out   <= r_asm;
                r_out_n <= r_idx;
                r_oval  <= 1'b1;
                r_asm   <= '0;
                r_idx   <= '0;
                r_pend  <= 1'b0;
            end else begin
                if (w_acc) begin
                    r_asm <= w_asm_new;
                    r_idx <= w_cnt_new;
                end
                if (w_xfer) begin
                    r_oval <= 1'b0;
                end
            end
            if (w_acc && (w_base_idx == '0)) begin
                r_tgt <= w_tgt_cur;
            end
            if ((i_enable & i_valid & r_pend) | w_sof_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_ready    = ~r_pend;
    assign o_valid    = r_oval;
    assign o_data     = r_out;
    assign o_n_lanes  = r_out_n;
    assign o_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_parallel_converter_1_to_n_flow.sv
`default_nettype none
// ============================================================================
// Module   : tb_parallel_converter_1_to_n_flow
// Purpose  : Directed scoreboard bench for parallel_converter_1_to_n_flow.
// Revision : 1.0
// ============================================================================
module tb_parallel_converter_1_to_n_flow;

    localparam int NB_DATA  = 67;
    localparam int N_LANES  = 20;
    localparam int NB_BUS   = NB_DATA * N_LANES;
    localparam int NB_COUNT = $clog2(N_LANES + 1);

    logic                i_clock = 1'b0;
    logic                i_reset = 1'b1;
    logic                i_enable = 1'b1;
    logic                i_valid = 1'b0;
    logic [NB_DATA-1:0]  i_data = '0;
    logic                i_flush = 1'b0;
    logic [NB_COUNT-1:0] i_n_lanes = NB_COUNT'(N_LANES);
    logic                i_ready = 1'b1;
    logic                i_sof = 1'b0;
    logic                o_ready;
    logic                o_valid;
    logic [NB_BUS-1:0]   o_data;
    logic [NB_COUNT-1:0] o_n_lanes;
    logic                o_overflow;

    parallel_converter_1_to_n_flow #(
        .NB_DATA (NB_DATA),
        .N_LANES (N_LANES)
    ) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_enable   (i_enable),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .i_flush    (i_flush),
        .i_n_lanes  (i_n_lanes),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_n_lanes  (o_n_lanes),
        .o_overflow (o_overflow)
`ifdef PAR_CONV_SOF_ALIGN_EN
        ,
        .i_sof      (i_sof)
`endif
    );

    always #5 i_clock = ~i_clock;

    int n_cmp = 0;
    int n_err = 0;

    logic [NB_BUS-1:0]  q_data[$];
    int                 q_n[$];
    logic [NB_DATA-1:0] cur[$];
    int                 tgt_m = N_LANES;

    function automatic logic [NB_DATA-1:0] blk(input int k);
        logic [NB_DATA-1:0] v;
        v = {3'b101, 32'hC0DE0000 ^ 32'(k), 32'(k)};
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_bundle();
        logic [NB_BUS-1:0] b;
        b = '0;
        for (int k = 0; k < cur.size(); k++) begin
            b[NB_BUS-1-k*NB_DATA -: NB_DATA] = cur[k];
        end
        q_data.push_back(b);
        q_n.push_back(cur.size());
        cur.delete();
    endtask

    task automatic model_accept(input logic [NB_DATA-1:0] d, input logic sof);
        if (sof && cur.size() > 0) cur.delete();
        if (cur.size() == 0) begin
            tgt_m = (i_n_lanes == 0 || int'(i_n_lanes) > N_LANES) ? N_LANES : int'(i_n_lanes);
        end
        cur.push_back(d);
        if (cur.size() == tgt_m) push_bundle();
    endtask

    // Called at posedge+1; o_ready is then stable up to the next edge
    task automatic send(input logic [NB_DATA-1:0] d, input logic sof = 1'b0);
        logic acc_exp;
        i_valid = 1'b1;
        i_data  = d;
        i_sof   = sof;
        acc_exp = o_ready;
        @(posedge i_clock);
        #1;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        if (acc_exp) model_accept(d, sof);
    endtask

    task automatic flush();
        i_flush = 1'b1;
        @(posedge i_clock);
        #1;
        i_flush = 1'b0;
        if (cur.size() > 0) push_bundle();
    endtask

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        while (q_data.size() != 0 && cyc < 200) begin
            @(posedge i_clock);
            #1;
            cyc++;
        end
        chk(tag, 64'(q_data.size()), 64'd0);
    endtask

    // Scoreboard: a transfer is taken at the next edge when these hold now
    always @(negedge i_clock) begin
        if (!i_reset && i_enable && o_valid && i_ready) begin
            n_cmp++;
            if (q_data.size() == 0) begin
                n_err++;
                $error("FAIL unexpected_bundle: observed n_lanes %0d expected none", o_n_lanes);
            end else begin
                logic [NB_BUS-1:0] ed;
                int                en;
                int                bad;
                ed  = q_data.pop_front();
                en  = q_n.pop_front();
                bad = -1;
                for (int k = N_LANES - 1; k >= 0; k--) begin
                    if (o_data[NB_BUS-1-k*NB_DATA -: NB_DATA] !== ed[NB_BUS-1-k*NB_DATA -: NB_DATA]) bad = k;
                end
                assert (o_data === ed && int'(o_n_lanes) == en) else begin
                    n_err++;
                    if (bad >= 0)
                        $error("FAIL bundle_slot%0d: observed %h expected %h", bad,
                               o_data[NB_BUS-1-bad*NB_DATA -: NB_DATA], ed[NB_BUS-1-bad*NB_DATA -: NB_DATA]);
                    else
                        $error("FAIL bundle_n_lanes: observed %0d expected %0d", o_n_lanes, en);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge i_clock);
        #1;
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_o_ready", 64'(o_ready), 64'd1);
        chk("rst_o_n_lanes", 64'(o_n_lanes), 64'd0);
        chk("rst_o_overflow", 64'(o_overflow), 64'd0);
        chk("rst_o_data_zero", 64'(|o_data), 64'd0);
        i_reset = 1'b0;

        // Two full bundles at full throughput
        i_n_lanes = 5'd20;
        i_ready   = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            send(blk(k));
            chk("full_o_ready", 64'(o_ready), 64'd1);
            if (k == 19 || k == 39) chk("full_valid_before", 64'(o_valid), 64'd0);
            if (k == 20 || k == 40) begin
                chk("full_valid_latency", 64'(o_valid), 64'd1);
                chk("full_n_lanes", 64'(o_n_lanes), 64'd20);
            end
        end
        drain("full_drain");

        // Short bundle, held by backpressure and then frozen by i_enable
        i_ready   = 1'b0;
        i_n_lanes = 5'd4;
        for (int k = 0; k < 4; k++) send(blk(32'hA0 + k));
        chk("short_valid", 64'(o_valid), 64'd1);
        chk("short_n_lanes", 64'(o_n_lanes), 64'd4);
        i_enable = 1'b0;
        i_ready  = 1'b1;
        repeat (3) @(posedge i_clock);
        #1;
        chk("enable_hold_valid", 64'(o_valid), 64'd1);
        chk("enable_hold_queue", 64'(q_data.size()), 64'd1);
        i_enable = 1'b1;
        drain("short_drain");

        // Partial bundle via flush, then flush with nothing buffered
        i_n_lanes = 5'd20;
        for (int k = 0; k < 7; k++) send(blk(32'hB0 + k));
        flush();
        chk("flush_valid", 64'(o_valid), 64'd1);
        chk("flush_n_lanes", 64'(o_n_lanes), 64'd7);
        drain("flush_drain");
        flush();
        chk("flush_empty_valid", 64'(o_valid), 64'd0);
        chk("flush_empty_queue", 64'(q_data.size()), 64'd0);

        // Lane count 0 clamps to N_LANES
        i_n_lanes = 5'd0;
        for (int k = 0; k < 20; k++) begin
            send(blk(32'hC0 + k));
            if (k == 18) chk("clamp_valid_before", 64'(o_valid), 64'd0);
        end
        chk("clamp_n_lanes", 64'(o_n_lanes), 64'd20);
        drain("clamp_drain");

        // Persistent backpressure: one bundle out, one pending, then overflow
        i_n_lanes = 5'd20;
        i_ready   = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            send(blk(32'h100 + k));
            if (k == 39) chk("bp_ready_39", 64'(o_ready), 64'd1);
            if (k == 40) chk("bp_ready_40", 64'(o_ready), 64'd0);
            if (k == 40) chk("bp_ovf_40", 64'(o_overflow), 64'd0);
        end
        chk("bp_overflow", 64'(o_overflow), 64'd1);
        i_ready = 1'b1;
        drain("bp_drain");
        chk("bp_ready_back", 64'(o_ready), 64'd1);

        // Asynchronous reset mid-bundle
        for (int k = 0; k < 9; k++) send(blk(32'h200 + k));
        #2;
        i_reset = 1'b1;
        #1;
        chk("arst_overflow", 64'(o_overflow), 64'd0);
        chk("arst_valid", 64'(o_valid), 64'd0);
        chk("arst_ready", 64'(o_ready), 64'd1);
        cur.delete();
        @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        for (int k = 0; k < 20; k++) send(blk(32'h300 + k));
        chk("arst_n_lanes", 64'(o_n_lanes), 64'd20);
        drain("arst_drain");

`ifdef PAR_CONV_SOF_ALIGN_EN
        // SOF discards the partial bundle and starts a new one
        for (int k = 0; k < 5; k++) send(blk(32'h400 + k));
        send(blk(32'h4FF), 1'b1);
        for (int k = 0; k < 19; k++) send(blk(32'h500 + k));
        chk("sof_overflow", 64'(o_overflow), 64'd1);
        chk("sof_n_lanes", 64'(o_n_lanes), 64'd20);
        drain("sof_drain");
`endif

        repeat (2) @(posedge i_clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
